// File: rtl/datapath_acc.sv
// Accumulation stage behind the arithmetic datapath: sums a programmed number of
// terms into a guard-banded accumulator and returns the raw and saturated sums.
module datapath_acc #(
    parameter int N      = 8,
    parameter int G      = 4,
    parameter int CW     = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CW-1:0]   len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    y_in,
    input  logic            co_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N+G-1:0]  acc_out,
    output logic [N-1:0]    sat_out,
    output logic            ovf,
    output logic            busy
);

    localparam int AW = N + G;
    localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic            ovfDir_q, ovfDir_d;

    logic [AW-1:0]   termSigned, termUnsigned, term;
    logic [AW:0]     sum;
    logic            signedOvf, ovfNow, posOvf;
    logic [N-1:0]    satVal;

    assign termSigned   = AW'(signed'(y_in));
    assign termUnsigned = AW'({co_in, y_in});
    assign term         = SIGNED ? termSigned : termUnsigned;
    assign sum          = {1'b0, acc_q} + {1'b0, term};

    // Signed overflow: both operands share a sign that the wrapped result lost.
    assign signedOvf = (acc_q[AW-1] == term[AW-1]) && (sum[AW-1] != acc_q[AW-1]);
    assign ovfNow    = SIGNED ? signedOvf : sum[AW];
    assign posOvf    = SIGNED ? ~acc_q[AW-1] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            ovfDir_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            ovfDir_q <= ovfDir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        ovfDir_d = ovfDir_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    ovfDir_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ACC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d = sum[AW-1:0];
                    cnt_d = cnt_q - CW'(1);
                    // Only the first overflow of a run decides the saturation direction.
                    if (ovfNow && !ovf_q) begin
                        ovf_d    = 1'b1;
                        ovfDir_d = posOvf;
                    end
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In range when every bit above the output width matches the output sign (or is zero).
    always_comb begin
        satVal = acc_q[N-1:0];
        if (SIGNED) begin
            if (ovf_q) begin
                satVal = ovfDir_q ? SMAX : SMIN;
            end else if (acc_q[AW-1:N-1] != {(G+1){acc_q[AW-1]}}) begin
                satVal = acc_q[AW-1] ? SMIN : SMAX;
            end
        end else begin
            if (ovf_q || (acc_q[AW-1:N] != '0)) begin
                satVal = '1;
            end
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign sat_out   = satVal;
    assign ovf       = ovf_q;

endmodule
